// File: rtl/icache_dm_fill.sv
// Direct-mapped instruction cache with a combinational hit path and a refill FSM
// that bursts a missed line in from the memory bus, one word per bus_ready.
module icache_dm_fill #(
  parameter int LINES      = 16,
  parameter int LINE_WORDS = 16
) (
  input  logic        clk,
  input  logic        rst_b,
  input  logic [31:0] rd_addr,
  input  logic        rd_req,
  output logic        rd_wait,
  output logic [31:0] rd_data,
  input  logic        inv,
  output logic        bus_rd,
  output logic [31:0] bus_addr,
  input  logic        bus_ready,
  input  logic [31:0] bus_rdata
);
  localparam int IDX_W = $clog2(LINES);
  localparam int OFF_W = $clog2(LINE_WORDS);
  localparam int TAG_W = 32 - IDX_W - OFF_W - 2;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_FILL = 1'b1;

  localparam logic [OFF_W-1:0] LAST = OFF_W'(LINE_WORDS - 1);

  logic [31:0]       data_mem [LINES*LINE_WORDS];
  logic [TAG_W-1:0]  tag_mem  [LINES];
  logic [LINES-1:0]  valid;

  logic [0:0]        state;
  logic [OFF_W-1:0]  cnt;
  logic [TAG_W-1:0]  fill_tag;
  logic [IDX_W-1:0]  fill_idx;

  logic [TAG_W-1:0]  rd_tag;
  logic [IDX_W-1:0]  rd_idx;
  logic [OFF_W-1:0]  rd_word;
  logic              hit;
  logic              beat;
  logic              last_beat;
  logic              unused_bits;

  assign rd_tag      = rd_addr[31 -: TAG_W];
  assign rd_idx      = rd_addr[IDX_W+OFF_W+1 : OFF_W+2];
  assign rd_word     = rd_addr[OFF_W+1 : 2];
  assign unused_bits = ^rd_addr[1:0];

  assign hit     = valid[rd_idx] && (tag_mem[rd_idx] == rd_tag);
  assign rd_wait = rd_req && !hit;
  assign rd_data = data_mem[{rd_idx, rd_word}];

  assign beat      = (state == S_FILL) && bus_ready;
  assign last_beat = beat && (cnt == LAST);

  assign bus_rd   = (state == S_FILL);
  assign bus_addr = {fill_tag, fill_idx, cnt, 2'b00};

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      state    <= S_IDLE;
      cnt      <= '0;
      fill_tag <= '0;
      fill_idx <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (rd_req && !hit && !inv) begin
            state    <= S_FILL;
            cnt      <= '0;
            fill_tag <= rd_tag;
            fill_idx <= rd_idx;
          end
        end
        default: begin
          // inv aborts the burst; partially written words stay behind an invalid line
          if (inv) begin
            state <= S_IDLE;
          end else if (bus_ready) begin
            cnt <= cnt + OFF_W'(1);
            if (cnt == LAST) state <= S_IDLE;
          end
        end
      endcase
    end
  end

  // inv takes priority over the final beat so a racing invalidate always wins
  always_ff @(posedge clk) begin
    if (!rst_b || inv) begin
      valid <= '0;
    end else if (last_beat) begin
      valid[fill_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_b && beat) begin
      data_mem[{fill_idx, cnt}] <= bus_rdata;
      if (cnt == LAST) tag_mem[fill_idx] <= fill_tag;
    end
  end

endmodule

// File: tb/tb_icache_dm_fill.sv
// Directed bench for icache_dm_fill: a bus model returning the address as data,
// table-driven hit/miss probes and hand-written refill, abort and reset sequences.
module tb_icache_dm_fill;
  logic        clk = 1'b0;
  logic        rst_b;
  logic [31:0] rd_addr;
  logic        rd_req;
  logic        rd_wait;
  logic [31:0] rd_data;
  logic        inv;
  logic        bus_rd;
  logic [31:0] bus_addr;
  logic        bus_ready;
  logic [31:0] bus_rdata;

  int n_chk  = 0;
  int n_fail = 0;

  icache_dm_fill #(.LINES(16), .LINE_WORDS(16)) dut (
    .clk(clk), .rst_b(rst_b), .rd_addr(rd_addr), .rd_req(rd_req),
    .rd_wait(rd_wait), .rd_data(rd_data), .inv(inv), .bus_rd(bus_rd),
    .bus_addr(bus_addr), .bus_ready(bus_ready), .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;
  assign bus_rdata = bus_addr;

  typedef struct {
    logic [31:0] addr;
    logic        req;
    logic        exp_wait;
    logic [31:0] exp_data;
  } probe_t;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // One lookup; rd_req is dropped before the edge so a miss never starts a fill.
  task automatic probe(input probe_t p);
    rd_addr = p.addr; rd_req = p.req; inv = 1'b0;
    #1;
    chk("probe_wait", 32'(rd_wait), 32'(p.exp_wait));
    if (p.req && !p.exp_wait) chk("probe_data", rd_data, p.exp_data);
    chk("probe_bus_rd", 32'(bus_rd), 32'h0);
    rd_req = 1'b0;
    step();
  endtask

  task automatic fill_line(input logic [31:0] a, input bit toggle, input int exp_cycles);
    logic [31:0] base;
    int beat_n, cyc;
    base = {a[31:6], 6'b0};
    beat_n = 0; cyc = 0;
    rd_addr = a; rd_req = 1'b1; inv = 1'b0; bus_ready = 1'b0;
    #1;
    chk("miss_wait", 32'(rd_wait), 32'h1);
    chk("idle_bus_rd", 32'(bus_rd), 32'h0);
    while (beat_n < 16 && cyc < 100) begin
      step();
      cyc++;
      bus_ready = toggle ? (cyc % 2 == 0) : 1'b1;
      #1;
      chk("fill_bus_rd", 32'(bus_rd), 32'h1);
      chk("fill_bus_addr", bus_addr, base + 32'(beat_n * 4));
      if (bus_ready) beat_n++;
    end
    step();
    bus_ready = 1'b0;
    #1;
    chk("fill_cycles", 32'(cyc), 32'(exp_cycles));
    chk("done_bus_rd", 32'(bus_rd), 32'h0);
    chk("done_wait", 32'(rd_wait), 32'h0);
    chk("done_data", rd_data, {a[31:2], 2'b00});
    rd_req = 1'b0;
  endtask

  probe_t t1 [5];
  probe_t t2 [7];

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    t1 = '{
      '{32'h0000_107C, 1'b1, 1'b0, 32'h0000_107C},
      '{32'h0000_1044, 1'b1, 1'b0, 32'h0000_1044},
      '{32'h0000_1440, 1'b1, 1'b1, 32'h0},
      '{32'h0000_2000, 1'b1, 1'b1, 32'h0},
      '{32'h0000_1040, 1'b0, 1'b0, 32'h0}
    };
    t2 = '{
      '{32'h0000_1440, 1'b1, 1'b0, 32'h0000_1440},
      '{32'h0000_147C, 1'b1, 1'b0, 32'h0000_147C},
      '{32'h0000_1040, 1'b1, 1'b1, 32'h0},
      '{32'h0000_23C0, 1'b1, 1'b0, 32'h0000_23C0},
      '{32'h0000_23FC, 1'b1, 1'b0, 32'h0000_23FC},
      '{32'h0000_2010, 1'b1, 1'b0, 32'h0000_2010},
      '{32'h0000_0000, 1'b1, 1'b1, 32'h0}
    };

    rst_b = 1'b0; rd_req = 1'b0; rd_addr = '0; inv = 1'b0; bus_ready = 1'b0;
    step(); step();
    rst_b = 1'b1;
    #1;
    chk("rst_bus_rd", 32'(bus_rd), 32'h0);
    chk("rst_wait_noreq", 32'(rd_wait), 32'h0);

    // basic refill, then hits/misses around it
    fill_line(32'h0000_1040, 1'b0, 16);
    foreach (t1[i]) probe(t1[i]);

    // conflict on idx 1, plus lines at idx 15 and idx 0
    fill_line(32'h0000_1440, 1'b0, 16);
    fill_line(32'h0000_23C0, 1'b0, 16);
    fill_line(32'h0000_2000, 1'b0, 16);
    foreach (t2[i]) probe(t2[i]);

    // stalled bus: ready toggles, fill spans 32 cycles
    fill_line(32'h0000_1040, 1'b1, 32);
    probe('{32'h0000_107C, 1'b1, 1'b0, 32'h0000_107C});
    probe('{32'h0000_1440, 1'b1, 1'b1, 32'h0});

    // inv on the 8th beat aborts, then the same address refills from word 0
    rd_addr = 32'h0000_3080; rd_req = 1'b1; bus_ready = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      step();
      if (k == 8) inv = 1'b1;
      #1;
      chk("abort_bus_addr", bus_addr, 32'h0000_3080 + 32'((k - 1) * 4));
    end
    step();
    inv = 1'b0;
    #1;
    chk("abort_bus_rd", 32'(bus_rd), 32'h0);
    chk("abort_wait", 32'(rd_wait), 32'h1);
    fill_line(32'h0000_3080, 1'b0, 16);
    probe('{32'h0000_107C, 1'b1, 1'b1, 32'h0});

    // inv in IDLE wipes the hit and suppresses a fill start
    rd_addr = 32'h0000_5000; rd_req = 1'b1; inv = 1'b1;
    #1;
    chk("inv_idle_wait", 32'(rd_wait), 32'h1);
    step();
    inv = 1'b0; rd_req = 1'b0;
    #1;
    chk("inv_suppress_bus_rd", 32'(bus_rd), 32'h0);
    probe('{32'h0000_3080, 1'b1, 1'b1, 32'h0});

    // inv racing the final beat leaves the line invalid
    rd_addr = 32'h0000_4100; rd_req = 1'b1; bus_ready = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      step();
      if (k == 16) inv = 1'b1;
      #1;
      chk("race_bus_addr", bus_addr, 32'h0000_4100 + 32'((k - 1) * 4));
    end
    step();
    inv = 1'b0; rd_req = 1'b0;
    #1;
    chk("race_bus_rd", 32'(bus_rd), 32'h0);
    probe('{32'h0000_4100, 1'b1, 1'b1, 32'h0});

    // reset mid-fill aborts and invalidates everything
    fill_line(32'h0000_3080, 1'b0, 16);
    rd_addr = 32'h0000_1040; rd_req = 1'b1; bus_ready = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      step();
      #1;
      chk("prerst_bus_addr", bus_addr, 32'h0000_1040 + 32'((k - 1) * 4));
    end
    rst_b = 1'b0;
    step();
    rst_b = 1'b1; rd_req = 1'b0;
    #1;
    chk("rst_abort_bus_rd", 32'(bus_rd), 32'h0);
    probe('{32'h0000_3080, 1'b1, 1'b1, 32'h0});
    probe('{32'h0000_1040, 1'b1, 1'b1, 32'h0});

    // rd_addr moving mid-fill does not redirect the burst
    rd_addr = 32'h0000_1040; rd_req = 1'b1; bus_ready = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      step();
      if (k == 5) rd_addr = 32'h0000_2000;
      #1;
      chk("redir_bus_addr", bus_addr, 32'h0000_1040 + 32'((k - 1) * 4));
    end
    step();
    #1;
    chk("redir_done_bus_rd", 32'(bus_rd), 32'h0);
    chk("redir_new_wait", 32'(rd_wait), 32'h1);
    rd_addr = 32'h0000_1040;
    #1;
    chk("redir_orig_wait", 32'(rd_wait), 32'h0);
    chk("redir_orig_data", rd_data, 32'h0000_1040);
    rd_addr = 32'h0000_2000;
    step();
    #1;
    chk("redir_next_bus_rd", 32'(bus_rd), 32'h1);
    chk("redir_next_bus_addr", bus_addr, 32'h0000_2000);
    inv = 1'b1;
    step();
    inv = 1'b0; rd_req = 1'b0;
    #1;
    chk("final_abort_bus_rd", 32'(bus_rd), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
